// File: rtl/tama_pkg.sv
// tama_pkg
// Shared definitions for the tamagotchi serial front-end and the stats block.
//   CMD_*         : canonical lowercase command bytes understood by the core
//   rx_state_t    : UART deserialiser state encoding
//   fold_lower()  : maps the uppercase form of a known command to lowercase
//   is_known_cmd(): true when a byte is one of the canonical commands
package tama_pkg;

    localparam logic [7:0] CMD_EAT   = 8'h65;  // 'e'
    localparam logic [7:0] CMD_PLAY  = 8'h70;  // 'p'
    localparam logic [7:0] CMD_BATH  = 8'h62;  // 'b'
    localparam logic [7:0] CMD_SLEEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_TALK  = 8'h74;  // 't'
    localparam logic [7:0] CMD_WAKE  = 8'h77;  // 'w'

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Only the six command letters are folded; every other byte passes
    // through untouched so that the acceptance check can reject it.
    function automatic logic [7:0] fold_lower(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b inside {8'h45, 8'h50, 8'h42, 8'h53, 8'h54, 8'h57}) begin
            r = b | 8'h20;
        end
        return r;
    endfunction

    function automatic logic is_known_cmd(input logic [7:0] b);
        return b inside {CMD_EAT, CMD_PLAY, CMD_BATH, CMD_SLEEP, CMD_TALK, CMD_WAKE};
    endfunction

endpackage

// File: rtl/rx_sync.sv
// rx_sync
// Two-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   reset : asynchronous active-high reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles behind d
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// 8N1 UART command receiver feeding the stats block. Each accepted byte is
// held on cmd for HOLD_CYCLES cycles and then cmd returns to 0x00; a byte
// arriving during a hold forces one 0x00 cycle before it is presented so the
// consumer always re-arms.
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   rx        : raw UART line, idle high, asynchronous to clk
//   cmd       : held command byte, 0x00 when nothing is presented
//   cmd_valid : one-cycle pulse when a new byte appears on cmd
//   frame_err : one-cycle pulse when a stop bit is sampled low
// Build option: define CMD_FILTER_EN to accept only the six command letters
// (uppercase folded to lowercase); otherwise every nonzero byte is accepted.
module uart_cmd_rx
    import tama_pkg::*;
#(
    parameter int CLK_HZ      = 27000000,
    parameter int BAUD        = 115200,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT) + 1;
    localparam int HOLD_W       = $clog2(HOLD_CYCLES) + 1;

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    logic              rx_s;
    logic              rx_prev_q, rx_prev_d;
    rx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              cand_valid;

    logic              accept;
    logic [7:0]        accept_byte;

    logic [7:0]        cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pend_q, pend_d;
    logic [7:0]        pend_byte_q, pend_byte_d;

    rx_sync #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    // Deserialiser. The baud counter free-runs inside a state and is cleared
    // at every sample point, so each sample lands mid-bit once START has
    // realigned to the centre of the start bit.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_prev_d   = rx_s;
        frame_err_d = 1'b0;
        cand_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                    state_d    = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d  = '0;
                    state_d     = IDLE;
                    cand_valid  = rx_s;
                    frame_err_d = !rx_s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CMD_FILTER_EN
    assign accept_byte = fold_lower(shift_q);
    assign accept      = cand_valid && is_known_cmd(accept_byte);
`else
    assign accept_byte = shift_q;
    assign accept      = cand_valid && (shift_q != 8'h00);
`endif

    // Hold stage. A new byte during an active hold drops cmd to 0x00 for one
    // cycle and parks the byte in pend_byte_q; it is presented the cycle after.
    always_comb begin
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        pend_d      = 1'b0;
        pend_byte_d = pend_byte_q;
        if (accept) begin
            if (hold_cnt_q != '0) begin
                cmd_d       = 8'h00;
                hold_cnt_d  = '0;
                pend_d      = 1'b1;
                pend_byte_d = accept_byte;
            end else begin
                cmd_d       = accept_byte;
                cmd_valid_d = 1'b1;
                hold_cnt_d  = HOLD_LOAD;
            end
        end else if (pend_q) begin
            cmd_d       = pend_byte_q;
            cmd_valid_d = 1'b1;
            hold_cnt_d  = HOLD_LOAD;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
            if (hold_cnt_q == HOLD_W'(1)) begin
                cmd_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rx_prev_q   <= 1'b1;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            cmd_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            pend_q      <= 1'b0;
            pend_byte_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            rx_prev_q   <= rx_prev_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            hold_cnt_q  <= hold_cnt_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;

endmodule
